// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the host sequencer and the autobaud controller.
// Start and Abort are single-cycle request pulses with no back-pressure; Done and Err are single-cycle result pulses.
interface uart_autobaud_if;
  logic        Rx;
  logic        Start;
  logic        Abort;
  logic [15:0] BaudRate;
  logic        Locked;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [1:0]  ErrCode;
  logic [2:0]  DbgState;

  modport master (
    output Rx, Start, Abort,
    input  BaudRate, Locked, Busy, Done, Err, ErrCode, DbgState
  );

  modport slave (
    input  Rx, Start, Abort,
    output BaudRate, Locked, Busy, Done, Err, ErrCode, DbgState
  );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Measures a 0x55 sync character on the RX line and derives the 16x-oversample
// baud divisor (T8 / 128, rounded half-up), holding the last good value.
module uart_autobaud_ctrl #(
  parameter int          CNT_W       = 24,
  parameter logic [15:0] DEFAULT_DIV = 16'd326,
  parameter logic [15:0] MIN_DIV     = 16'd2
) (
  input logic            Clk,
  input logic            Rst,
  uart_autobaud_if.slave bus
);
  localparam int T8_W  = CNT_W + 2;
  localparam int DIV_W = (T8_W + 1 > 17) ? T8_W + 1 : 17;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_FALL = 3'd2,
    S_MEASURE   = 3'd3,
    S_WAIT_STOP = 3'd4,
    S_CALC      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_i1;
  logic [T8_W-1:0]  r_t8;
  logic [2:0]       r_edges;
  logic [1:0]       r_pend_code;
  logic [1:0]       r_err_code;
  logic [15:0]      r_baud;
  logic             r_locked;
  logic             r_done;
  logic             r_err;

  logic             w_fall;
  logic             w_rise;
  logic             w_timeout;
  logic             w_mismatch;
  logic             w_range_bad;
  logic [1:0]       w_err_code;
  logic [CNT_W-1:0] w_ik;
  logic [CNT_W-1:0] w_diff;
  logic [DIV_W-1:0] w_div;

  // Edges come from the synchronized line, so the synchronizer latency cancels in every interval.
  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_rise      = ~r_rx_prev & r_rx_sync;
  assign w_ik        = r_cnt + 1'b1;
  assign w_diff      = (w_ik > r_i1) ? (w_ik - r_i1) : (r_i1 - w_ik);
  assign w_mismatch  = w_diff > (r_i1 >> 3);
  assign w_timeout   = &r_cnt;
  assign w_div       = (DIV_W'(r_t8) + DIV_W'(64)) >> 7;
  assign w_range_bad = (w_div < DIV_W'(MIN_DIV)) || (w_div > DIV_W'(17'h0FFFF));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_code = 2'd0;
    case (r_state)
      S_IDLE:      if (bus.Start) w_next = S_ARM;
      S_ARM:       if (r_rx_sync) w_next = S_WAIT_FALL;
      S_WAIT_FALL: if (w_fall) w_next = S_MEASURE;
      S_MEASURE: begin
        if (w_timeout) begin
          w_next     = S_ERROR;
          w_err_code = ERR_TIMEOUT;
        end else if (w_fall) begin
          if (r_edges >= 3'd2 && w_mismatch) begin
            w_next     = S_ERROR;
            w_err_code = ERR_MISMATCH;
          end else if (r_edges == 3'd4) begin
            w_next = S_WAIT_STOP;
          end
        end
      end
      S_WAIT_STOP: begin
        if (w_timeout) begin
          w_next     = S_ERROR;
          w_err_code = ERR_TIMEOUT;
        end else if (w_rise) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_range_bad) begin
          w_next     = S_ERROR;
          w_err_code = ERR_RANGE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ERROR:     w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    // Abort wins over any edge or completion seen in the same cycle.
    if (r_state != S_IDLE && bus.Abort) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_i1        <= '0;
      r_t8        <= '0;
      r_edges     <= 3'd0;
      r_pend_code <= 2'd0;
      r_err_code  <= 2'd0;
      r_baud      <= DEFAULT_DIV;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rx_meta <= bus.Rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      if (w_next == S_ERROR && r_state != S_ERROR) r_pend_code <= w_err_code;
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_locked   <= 1'b0;
            r_err_code <= 2'd0;
          end
        end
        S_WAIT_FALL: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_t8    <= '0;
            r_edges <= 3'd1;
          end
        end
        S_MEASURE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_t8    <= r_t8 + T8_W'(w_ik);
            r_edges <= r_edges + 3'd1;
            if (r_edges == 3'd1) r_i1 <= w_ik;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_STOP: r_cnt <= r_cnt + 1'b1;
        S_CALC: begin
          if (!bus.Abort && !w_range_bad) begin
            r_baud   <= w_div[15:0];
            r_locked <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        S_ERROR: begin
          if (!bus.Abort) begin
            r_err      <= 1'b1;
            r_err_code <= r_pend_code;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BaudRate = r_baud;
  assign bus.Locked   = r_locked;
  assign bus.Busy     = (r_state != S_IDLE);
  assign bus.Done     = r_done;
  assign bus.Err      = r_err;
  assign bus.ErrCode  = r_err_code;
  assign bus.DbgState = r_state;
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: table of sync-character rates plus hand sequences
// for mismatch, timeout, abort, reset and ignored Start.
module tb_uart_autobaud_ctrl;
  localparam int          CNT_W      = 13;
  localparam logic [15:0] DEF_DIV    = 16'd326;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_MEASURE = 3'd3;

  typedef struct {
    int          period;
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [15:0] exp_baud;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  vec_t        vecs[5];

  uart_autobaud_if bus();

  uart_autobaud_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #(990000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every Done/Err pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && (bus.Done || bus.Err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: Done=%0b Err=%0b ErrCode=%0d BaudRate=%0d, expected no event",
                 bus.Done, bus.Err, bus.ErrCode, bus.BaudRate);
      end else begin
        mon_e = exp_q.pop_front();
        check("event", {12'd0, bus.Done, bus.Err, bus.ErrCode, bus.BaudRate}, {12'd0, mon_e});
        check("locked_at_event", 32'(bus.Locked), 32'(mon_e[19]));
        check("busy_at_event", 32'(bus.Busy), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.Rx = v;
    cyc(n);
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    cyc(1);
    bus.Start = 1'b0;
  endtask

  task automatic send_55(input int p);
    logic [7:0] d;
    d = 8'h55;
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    hold(1'b1, p);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int          p_rand;
    logic [15:0] rand_div;
    logic [15:0] last_baud;
    logic [7:0]  d;

    bus.Rx    = 1'b1;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    rst       = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_baud", 32'(bus.BaudRate), 32'(DEF_DIV));
    check("rst_locked", 32'(bus.Locked), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_err", 32'(bus.Err), 32'd0);
    check("rst_errcode", 32'(bus.ErrCode), 32'd0);
    check("rst_state", 32'(bus.DbgState), 32'(ST_IDLE));

    p_rand   = $urandom_range(600, 100);
    rand_div = 16'((8 * p_rand + 64) >> 7);
    vecs[0]  = '{1667,   1'b1, 2'd0, 16'd104};
    vecs[1]  = '{800,    1'b1, 2'd0, 16'd50};
    vecs[2]  = '{p_rand, 1'b1, 2'd0, rand_div};
    vecs[3]  = '{16,     1'b0, 2'd3, rand_div};
    vecs[4]  = '{1600,   1'b1, 2'd0, 16'd100};

    for (int i = 0; i < 5; i++) begin
      pulse_start();
      @(negedge clk);
      check("locked_after_start", 32'(bus.Locked), 32'd0);
      check("busy_after_start", 32'(bus.Busy), 32'd1);
      exp_q.push_back({vecs[i].exp_done, ~vecs[i].exp_done, vecs[i].exp_code, vecs[i].exp_baud});
      send_55(vecs[i].period);
      hold(1'b1, 8);
      wait_drain("vec", 64);
      check("vec_locked", 32'(bus.Locked), 32'(vecs[i].exp_done));
      check("vec_errcode", 32'(bus.ErrCode), 32'(vecs[i].exp_code));
      check("vec_baud", 32'(bus.BaudRate), 32'(vecs[i].exp_baud));
      check("vec_busy", 32'(bus.Busy), 32'd0);
    end

    // Reset mid-measurement after the lock at 100.
    pulse_start();
    hold(1'b0, 100);
    @(negedge clk);
    check("rst_mid_state", 32'(bus.DbgState), 32'(ST_MEASURE));
    rst = 1'b1;
    cyc(1);
    rst    = 1'b0;
    bus.Rx = 1'b1;
    @(negedge clk);
    check("rst_mid_baud", 32'(bus.BaudRate), 32'(DEF_DIV));
    check("rst_mid_locked", 32'(bus.Locked), 32'd0);
    check("rst_mid_busy", 32'(bus.Busy), 32'd0);
    hold(1'b1, 20);

    // Start pulse in the middle of a measurement must not disturb it.
    d = 8'h55;
    pulse_start();
    exp_q.push_back({1'b1, 1'b0, 2'd0, 16'd6});
    hold(1'b0, 100);
    hold(1'b1, 50);
    bus.Start = 1'b1;
    cyc(1);
    bus.Start = 1'b0;
    hold(1'b1, 49);
    for (int i = 1; i < 8; i++) hold(d[i], 100);
    hold(1'b1, 100);
    wait_drain("start_ignored", 64);
    check("start_ignored_baud", 32'(bus.BaudRate), 32'd6);
    last_baud = 16'd6;

    // Second interval 3700 against a 3200 reference.
    pulse_start();
    exp_q.push_back({1'b0, 1'b1, 2'd2, last_baud});
    hold(1'b0, 1600);
    hold(1'b1, 1600);
    hold(1'b0, 1850);
    hold(1'b1, 1850);
    hold(1'b0, 200);
    hold(1'b1, 50);
    wait_drain("mismatch", 64);
    check("mismatch_locked", 32'(bus.Locked), 32'd0);
    check("mismatch_errcode", 32'(bus.ErrCode), 32'd2);
    check("mismatch_baud", 32'(bus.BaudRate), 32'(last_baud));

    // One edge, then the line stays low until the counter saturates.
    pulse_start();
    exp_q.push_back({1'b0, 1'b1, 2'd1, last_baud});
    hold(1'b0, 8300);
    hold(1'b1, 10);
    wait_drain("timeout", 64);
    check("timeout_errcode", 32'(bus.ErrCode), 32'd1);
    check("timeout_state", 32'(bus.DbgState), 32'(ST_IDLE));

    // Abort after the third falling edge.
    pulse_start();
    hold(1'b0, 800);
    hold(1'b1, 800);
    hold(1'b0, 800);
    hold(1'b1, 800);
    hold(1'b0, 6);
    @(negedge clk);
    check("abort_pre_state", 32'(bus.DbgState), 32'(ST_MEASURE));
    bus.Abort = 1'b1;
    cyc(1);
    bus.Abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_state", 32'(bus.DbgState), 32'(ST_IDLE));
    hold(1'b1, 1700);
    check("abort_baud", 32'(bus.BaudRate), 32'(last_baud));
    check("abort_locked", 32'(bus.Locked), 32'd0);
    check("abort_errcode", 32'(bus.ErrCode), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Configures the 16x-oversample baud tick generator from the line rate instead of a fixed divisor.
- On request, it measures an incoming 0x55 sync character on the UART RX line and computes the 16-bit divisor value, where tick period = divisor clocks.
- Drives the generator's BaudRate input and holds the last good value until the next successful lock.
- Sits between the RX pin and the tick generator, sequenced by the host or control FSM.

Parameters:
- CNT_W, 24, width of the interval counter (covers divisors up to 65535).
- DEFAULT_DIV, 16'd326, BaudRate value after reset.
- MIN_DIV, 16'd2, smallest legal computed divisor.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Rx  in  1  raw UART RX line (asynchronous), idle high.
- Start  in  1  single-cycle pulse that begins a measurement.
- Abort  in  1  single-cycle pulse that cancels a measurement.
- BaudRate  out  16  divisor for the tick generator.
- Locked  out  1  BaudRate holds a measured value.
- Busy  out  1  measurement in progress.
- Done  out  1  one-cycle pulse when a new BaudRate is valid.
- Err  out  1  one-cycle pulse when a measurement fails.
- ErrCode  out  2  cause of last failure: 0 none, 1 timeout, 2 interval mismatch, 3 range.

Behaviour:
- Rx passes through a 2-flop synchronizer (reset value 1), followed by an edge register. All intervals are measured on the synchronized signal, so the synchronizer delay cancels out.
- Reset values: BaudRate=DEFAULT_DIV, Locked=0, Busy=0, Done=0, Err=0, ErrCode=0, state=IDLE, counters=0.
- Sync char 0x55 sent LSB first gives falling edges at the start bit and at the start of b1, b3, b5 and b7. Edges 1 to 5 span 8 bit periods (T8). Each edge-to-edge interval Ik, k=1..4, is 2 bit periods.
- FSM states:
  - IDLE: Busy=0. Start -> ARM and clears Locked and ErrCode. Start is ignored in every other state.
  - ARM: wait for the synchronized line to be high -> WAIT_FALL. Being low here is not an error.
  - WAIT_FALL: first falling edge -> MEASURE, clear the counter, edge count=1. No timeout here.
  - MEASURE: counter increments every cycle.
    - On each falling edge, latch Ik = counter+1, add it to T8, restart the counter, increment the edge count.
    - k=1: store I1 as the reference.
    - k>=2: if |Ik-I1| > (I1>>3), go to ERROR with code 2.
    - After the 5th falling edge -> WAIT_STOP.
  - WAIT_STOP: rising edge (stop bit) -> CALC.
  - CALC (1 cycle): div = (T8+64)>>7. If div < MIN_DIV or div > 65535, go to ERROR with code 3. Otherwise load BaudRate=div[15:0], set Locked=1, pulse Done, -> IDLE.
  - ERROR (1 cycle): pulse Err, latch ErrCode, -> IDLE. BaudRate and Locked=0 are left unchanged.
- Timeout: if the counter reaches all ones in MEASURE or WAIT_STOP, go to ERROR with code 1.
- Busy=1 in every state except IDLE.
- Abort in any non-IDLE state -> IDLE next cycle, with no Done, no Err and BaudRate unchanged. Abort has priority over a same-cycle edge or completion.
- Rst mid-measurement restores all reset values, including BaudRate=DEFAULT_DIV.
- Done and Err are never asserted together. Done is asserted 1 cycle after the stop-bit rising edge is registered.
- Widths: the T8 accumulator is CNT_W+2 bits. Rounding is half-up.

Test Plan:
- Reset, then Start; send 0x55 with bit period 1600 clocks -> T8=12800, Done pulse, BaudRate=100, Locked=1, ErrCode=0, Busy falls with Done.
- Send 0x55 with bit period 1667 clocks -> T8=13336, BaudRate=104. Then Start again and send bit period 800 -> BaudRate=50. Locked is 0 between Start and Done.
- First interval 3200 clocks, second 3700 (|diff| 500 > 400) -> Err pulse, ErrCode=2, BaudRate keeps its previous value, Locked=0.
- Bit period 16 clocks -> div=1 < MIN_DIV -> Err, ErrCode=3. No Done pulse.
- Start, one falling edge, then Rx held low for 2^24 cycles -> Err, ErrCode=1, returns to IDLE. Repeat with Abort after the 3rd edge -> no Done, no Err, Busy=0 next cycle.
- Rst asserted mid-MEASURE after a prior lock at 100 -> BaudRate=DEFAULT_DIV, Locked=0, Busy=0. A Start pulse while Busy is ignored, so the measurement result is unaffected.
